sha3_axis_arbiter: RTL

Packet-granular round-robin arbiter that shares one AXI-Stream output between N_SRC AXI-Stream sources, e.g. several message loaders feeding the single SHA-3 absorb stream. A grant is held from the first beat of a packet until its TLAST beat is accepted, so packets are never interleaved. The output side is one registered stage, so TDATA/TVALID/TLAST toward the core come straight from flops.

---
 rtl/sha3_axis_pkg.sv | 44 ++++
 rtl/sha3_axis_out_reg.sv | 51 +++++
 rtl/sha3_axis_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sha3_axis_pkg.sv
// -----------------------------------------------------------------------------
// sha3_axis_pkg
// Shared types, constants and the round-robin pick helper for the SHA-3
// AXI-Stream arbiter and its output register stage.
//   arb_state_t : arbiter FSM states (IDLE, ARB, XFER)
//   TKEEP_ALL   : all-ones source for M_TKEEP / M_TSTRB (sliced to width)
//   TDEST_ZERO  : constant M_TDEST value
//   rr_pick     : first requester searching upward from (last+1) mod n
// -----------------------------------------------------------------------------
package sha3_axis_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  localparam int          MAX_SRC    = 8;
  localparam logic [63:0] TKEEP_ALL  = '1;
  localparam logic        TDEST_ZERO = 1'b0;

  // Returns the index of the first set bit of req at or after (last+1),
  // wrapping modulo n. If req is empty the result is last; callers qualify
  // the pick with |req. The loop has a fixed trip count of MAX_SRC so it
  // unrolls cleanly; iterations with k > n are masked off.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int unsigned n);
    logic [2:0]  pick;
    logic        hit;
    int unsigned idx;
    pick = last;
    hit  = 1'b0;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      idx = (32'(last) + k) % n;
      if (!hit && (k <= n) && req[idx[2:0]]) begin
        pick = idx[2:0];
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sha3_axis_out_reg.sv
// -----------------------------------------------------------------------------
// sha3_axis_out_reg
// One registered stream stage: the downstream sees valid/payload straight
// from flops. Reusable by any stream block that needs a registered output.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_load        : load i_data this cycle (caller only asserts it while
//                   o_can_load is high)
//   i_data        : payload to load
//   i_ready       : downstream ready
//   o_valid       : registered valid
//   o_data        : registered payload
//   o_can_load    : stage is empty or draining this cycle
// Handshake: a beat moves downstream on a rising edge where o_valid and
// i_ready are both high; o_valid/o_data never change while o_valid is high
// and i_ready is low; o_can_load is the upstream ready term.
// -----------------------------------------------------------------------------
module sha3_axis_out_reg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_can_load
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_can_load = !r_valid || i_ready;
  assign o_valid    = r_valid;
  assign o_data     = r_data;

  // Holding while stalled is implicit: i_load is gated by o_can_load, and
  // valid only clears when the downstream takes the beat.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sha3_axis_arbiter.sv
// -----------------------------------------------------------------------------
// sha3_axis_arbiter
// Packet-granular round-robin arbiter sharing one AXI-Stream output between
// N_SRC sources. A grant is held from the first beat until the TLAST beat is
// accepted, so packets never interleave. Output goes through one register.
//   ACLK, ARESET        : clock, synchronous active-high reset
//   S_TVALID/S_TREADY   : per-source handshake (N_SRC bits)
//   S_TDATA/S_TUSER     : per-source payload, source i at [i*W +: W]
//   S_TLAST             : per-source last
//   M_TVALID/M_TREADY   : output handshake
//   M_TDATA/M_TUSER     : payload of the granted source
//   M_TLAST, M_TID      : last flag and index of the producing source
//   M_TKEEP/M_TSTRB     : constant all-ones; M_TDEST constant 0
//   arbstate            : ASCII state name, only with SHA3_AXIS_ARB_STATE_STR_EN
// Handshake: a beat transfers on a rising edge where VALID and READY are both
// high; VALID must not depend on READY; S_TREADY is combinational from
// M_TVALID/M_TREADY for the granted source only.
// -----------------------------------------------------------------------------
module sha3_axis_arbiter
  import sha3_axis_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 3,
  parameter int ID_WIDTH   = $clog2(N_SRC)
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [N_SRC-1:0]            S_TVALID,
  output logic [N_SRC-1:0]            S_TREADY,
  input  logic [N_SRC*DATA_WIDTH-1:0] S_TDATA,
  input  logic [N_SRC-1:0]            S_TLAST,
  input  logic [N_SRC*USER_WIDTH-1:0] S_TUSER,
  input  logic                        M_TREADY,
  output logic                        M_TVALID,
  output logic [DATA_WIDTH-1:0]       M_TDATA,
  output logic                        M_TLAST,
  output logic [USER_WIDTH-1:0]       M_TUSER,
  output logic [ID_WIDTH-1:0]         M_TID,
  output logic [DATA_WIDTH/8-1:0]     M_TKEEP,
  output logic [DATA_WIDTH/8-1:0]     M_TSTRB,
`ifdef SHA3_AXIS_ARB_STATE_STR_EN
  output logic [127:0]                arbstate,
`endif
  output logic                        M_TDEST
);

  localparam int OUT_W = 1 + USER_WIDTH + ID_WIDTH + DATA_WIDTH;

  arb_state_t          r_state, w_next_state;
  logic [ID_WIDTH-1:0] r_grant, w_next_grant;
  logic [ID_WIDTH-1:0] r_last,  w_next_last;
  logic [2:0]          w_pick;
  logic                w_can_load;
  logic                w_accept;
  logic [OUT_W-1:0]    w_out_d;
  logic [OUT_W-1:0]    w_out_q;

  assign w_pick = rr_pick(8'(S_TVALID), 3'(r_last), N_SRC);

  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant;
    w_next_last  = r_last;
    w_accept     = 1'b0;
    S_TREADY     = '0;
    case (r_state)
      IDLE: w_next_state = ARB;
      ARB: begin
        if (|S_TVALID) begin
          w_next_state = XFER;
          w_next_grant = ID_WIDTH'(w_pick);
          w_next_last  = ID_WIDTH'(w_pick);
        end
      end
      XFER: begin
        S_TREADY[r_grant] = w_can_load;
        w_accept          = S_TVALID[r_grant] && w_can_load;
        if (w_accept && S_TLAST[r_grant]) w_next_state = ARB;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= ID_WIDTH'(N_SRC - 1);
    end else begin
      r_state <= w_next_state;
      r_grant <= w_next_grant;
      r_last  <= w_next_last;
    end
  end

  assign w_out_d = {S_TLAST[r_grant],
                    S_TUSER[r_grant*USER_WIDTH +: USER_WIDTH],
                    r_grant,
                    S_TDATA[r_grant*DATA_WIDTH +: DATA_WIDTH]};

  sha3_axis_out_reg #(.W(OUT_W)) u_out_reg (
    .i_clk      (ACLK),
    .i_rst      (ARESET),
    .i_load     (w_accept),
    .i_data     (w_out_d),
    .i_ready    (M_TREADY),
    .o_valid    (M_TVALID),
    .o_data     (w_out_q),
    .o_can_load (w_can_load)
  );

  assign {M_TLAST, M_TUSER, M_TID, M_TDATA} = w_out_q;
  assign M_TKEEP = TKEEP_ALL[DATA_WIDTH/8-1:0];
  assign M_TSTRB = TKEEP_ALL[DATA_WIDTH/8-1:0];
  assign M_TDEST = TDEST_ZERO;

`ifdef SHA3_AXIS_ARB_STATE_STR_EN
  always_comb begin
    arbstate = {16{8'h20}};
    case (r_state)
      IDLE:    arbstate = "IDLE            ";
      ARB:     arbstate = "ARB             ";
      XFER:    arbstate = "XFER            ";
      default: arbstate = {16{8'h20}};
    endcase
  end
`endif

endmodule
